// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and serial line levels.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_tx_state_t;

   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;
   localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO; the head entry is always visible on rd_data.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int PTR_WIDTH  = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty
);

   localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_WIDTH:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH:0]    rd_ptr_q, rd_ptr_d;
   logic                  push, pop;

   // Extra pointer MSB tells a full ring apart from an empty one.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                  (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);

   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr_q[PTR_WIDTH-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr_q[PTR_WIDTH-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered 8N1 serializer with back-to-back frames.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int CLKS_PER_BIT = 868,
   parameter int PTR_WIDTH    = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  empty,
   output logic                  tx,
   output logic                  busy
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

   uart_tx_state_t        state_q, state_d;
   logic [BAUD_W-1:0]     baud_q, baud_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_empty, fifo_full;
   logic                  baud_last;

   uart_tx_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .PTR_WIDTH  (PTR_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (fifo_rd_en),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign full      = fifo_full;
   assign empty     = fifo_empty;
   assign tx        = tx_q;
   assign busy      = (state_q != IDLE);
   assign baud_last = (baud_q == BAUD_LAST);

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_last ? '0 : baud_q + BAUD_ONE;
      bit_d      = bit_q;
      shift_d    = shift_q;
      fifo_rd_en = 1'b0;
      tx_d       = IDLE_LEVEL;

      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               shift_d    = fifo_rd_data;
               fifo_rd_en = 1'b1;
               state_d    = START;
            end
         end
         START: begin
            if (baud_last) begin
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_last) begin
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) state_d = STOP;
               else                   bit_d   = bit_q + BIT_ONE;
            end
         end
         STOP: begin
            // Chain straight into the next start bit so frames have no idle gap.
            if (baud_last) begin
               if (!fifo_empty) begin
                  shift_d    = fifo_rd_data;
                  fifo_rd_en = 1'b1;
                  state_d    = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level follows the state being entered, so tx is a clean register.
      case (state_d)
         START:   tx_d = START_LEVEL;
         DATA:    tx_d = shift_d[0];
         STOP:    tx_d = STOP_LEVEL;
         default: tx_d = IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= IDLE_LEVEL;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: queue-and-frame-offset reference model plus directed timing checks.
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 16;
   localparam int DW    = 8;
   localparam int FRAME = (DW + 2) * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full, empty, tx, busy;

   always #5 clk = ~clk;

   uart_tx #(
      .DATA_WIDTH   (DW),
      .FIFO_DEPTH   (DEPTH),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .empty   (empty),
      .tx      (tx),
      .busy    (busy)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;
   int busy_cnt = 0;

   // Reference model: pending bytes, and position within the frame on the line.
   logic [7:0] q[$];
   logic       m_active = 1'b0;
   logic [7:0] m_byte   = 8'h00;
   int         m_off    = 0;

   logic tx_tr   [0:255];
   logic busy_tr [0:255];
   logic full_tr [0:255];

   function automatic logic exp_tx();
      int b;
      if (!m_active) return 1'b1;
      b = m_off / CPB;
      if (b == 0) return 1'b0;
      if (b <= DW) return m_byte[b-1];
      return 1'b1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic we, input logic [7:0] d);
      logic full_now, pop;
      if (r) begin
         q.delete();
         m_active = 1'b0;
         m_off    = 0;
         return;
      end
      full_now = (q.size() == DEPTH);
      pop = 1'b0;
      if (!m_active || m_off == FRAME - 1) pop = (q.size() > 0);
      if (pop) begin
         m_byte   = q.pop_front();
         m_active = 1'b1;
         m_off    = 0;
      end else if (m_active) begin
         m_off++;
         if (m_off == FRAME) begin
            m_active = 1'b0;
            m_off    = 0;
         end
      end
      if (we && !full_now) q.push_back(d);
   endtask

   task automatic step(input logic r, input logic we, input logic [7:0] d);
      logic acc;
      rst = r; wr_en = we; wr_data = d;
      acc = (q.size() != DEPTH);
      @(posedge clk);
      model_edge(r, we, d);
      #1;
      if (we) $display("push cycle %0d data %02h %s", cyc, d, (acc && !r) ? "accepted" : "dropped");
      cyc++;
      rst = 1'b0; wr_en = 1'b0;
      check("tx",    {31'd0, tx},    {31'd0, exp_tx()});
      check("busy",  {31'd0, busy},  {31'd0, m_active});
      check("empty", {31'd0, empty}, {31'd0, (q.size() == 0)});
      check("full",  {31'd0, full},  {31'd0, (q.size() == DEPTH)});
      if (busy === 1'b1) busy_cnt++;
      if (cyc < 256) begin
         tx_tr[cyc]   = tx;
         busy_tr[cyc] = busy;
         full_tr[cyc] = full;
      end
   endtask

   task automatic new_scenario();
      cyc = 0;
      busy_cnt = 0;
   endtask

   initial begin
      logic [7:0] b;
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;

      // Reset, then 20 idle cycles
      repeat (3) step(1'b1, 1'b0, 8'h00);
      new_scenario();
      repeat (20) step(1'b0, 1'b0, 8'h00);
      check("idle_busy_cnt", busy_cnt, 0);
      check("idle_tx", {31'd0, tx}, 1);

      // Single 0xA5 frame
      new_scenario();
      step(1'b0, 1'b1, 8'hA5);
      while (cyc < 45) step(1'b0, 1'b0, 8'h00);
      check("a5_pre_start", {31'd0, tx_tr[1]}, 1);
      check("a5_start",     {31'd0, tx_tr[2]}, 0);
      check("a5_start_end", {31'd0, tx_tr[5]}, 0);
      check("a5_bit0",      {31'd0, tx_tr[6]}, 1);
      check("a5_bit1",      {31'd0, tx_tr[10]}, 0);
      check("a5_bit7",      {31'd0, tx_tr[37]}, 1);
      check("a5_stop",      {31'd0, tx_tr[41]}, 1);
      check("a5_busy_rise", {31'd0, busy_tr[2]}, 1);
      check("a5_busy_last", {31'd0, busy_tr[41]}, 1);
      check("a5_busy_fall", {31'd0, busy_tr[42]}, 0);
      check("a5_busy_cnt",  busy_cnt, FRAME);

      // Three back-to-back frames
      new_scenario();
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 8'hFF);
      step(1'b0, 1'b1, 8'h3C);
      while (cyc < 130) step(1'b0, 1'b0, 8'h00);
      check("b2b_start0", {31'd0, tx_tr[2]},  0);
      check("b2b_stop0",  {31'd0, tx_tr[41]}, 1);
      check("b2b_start1", {31'd0, tx_tr[42]}, 0);
      check("b2b_stop1",  {31'd0, tx_tr[81]}, 1);
      check("b2b_start2", {31'd0, tx_tr[82]}, 0);
      check("b2b_nogap",  {31'd0, busy_tr[42] & busy_tr[82]}, 1);
      check("b2b_busy_cnt", busy_cnt, 3 * FRAME);

      // Overfill: 18 pushes, then 0x77 pushed while full as a pop happens
      new_scenario();
      for (int i = 0; i < 18; i++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'h77) b = 8'h78;
         step(1'b0, 1'b1, b);
      end
      check("ovf_not_full_16", {31'd0, full_tr[16]}, 0);
      check("ovf_full_17",     {31'd0, full_tr[17]}, 1);
      while (cyc < 41) step(1'b0, 1'b0, 8'h00);
      check("ovf_full_at_pop", {31'd0, full}, 1);
      step(1'b0, 1'b1, 8'h77);
      repeat (17 * FRAME + 20) step(1'b0, 1'b0, 8'h00);
      check("ovf_busy_cnt", busy_cnt, 17 * FRAME);
      check("ovf_empty_end", {31'd0, empty}, 1);

      // Reset during data bit 3 of the first of three frames
      new_scenario();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
      while (cyc < 18) step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      check("rst_tx",    {31'd0, tx},    1);
      check("rst_busy",  {31'd0, busy},  0);
      check("rst_empty", {31'd0, empty}, 1);
      busy_cnt = 0;
      repeat (100) step(1'b0, 1'b0, 8'h00);
      check("rst_no_frames", busy_cnt, 0);

      new_scenario();
      step(1'b0, 1'b1, 8'h5A);
      while (cyc < 50) step(1'b0, 1'b0, 8'h00);
      check("5a_start", {31'd0, tx_tr[2]},  0);
      check("5a_bit0",  {31'd0, tx_tr[6]},  0);
      check("5a_bit1",  {31'd0, tx_tr[10]}, 1);
      check("5a_bit7",  {31'd0, tx_tr[34]}, 0);
      check("5a_busy_cnt", busy_cnt, FRAME);

      // Random pushes against the reference model, then drain
      new_scenario();
      repeat (400) begin
         if ($urandom_range(0, 3) == 0) step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
         else                           step(1'b0, 1'b0, 8'h00);
      end
      repeat (DEPTH * FRAME + 2 * FRAME) step(1'b0, 1'b0, 8'h00);
      check("rand_drained_busy",  {31'd0, busy},  0);
      check("rand_drained_empty", {31'd0, empty}, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit path: a byte-wide transmit FIFO feeding an 8N1 serializer. Host logic pushes bytes with a write strobe. The block drains the FIFO and drives the `tx` line with start, data (LSB first) and stop bits at a fixed bit period. It is the transmit counterpart to the receive FIFO in the UART subsystem.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame and FIFO word width.
- `FIFO_DEPTH`, default 16: FIFO entries; must be a power of 2 and at least 2.
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200); must be at least 2.
- `PTR_WIDTH`, default `$clog2(FIFO_DEPTH)`: FIFO address width; pointers are `PTR_WIDTH+1` bits.

Ports:
- `clk`, input, 1: single clock; all logic acts on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `wr_en`, input, 1: push strobe; one byte per cycle.
- `wr_data`, input, `DATA_WIDTH`: byte to push, sampled when `wr_en` is high.
- `full`, output, 1: FIFO holds `FIFO_DEPTH` entries.
- `empty`, output, 1: FIFO holds 0 entries.
- `tx`, output, 1: serial line; idles high; registered.
- `busy`, output, 1: a frame is in progress (state is not IDLE).

## Operation
- Reset: `tx`=1, `busy`=0, `empty`=1, `full`=0. State goes to IDLE. Both FIFO pointers and all counters go to 0. FIFO contents are discarded.
- FIFO push: a write is accepted only when `wr_en` is high and `full` is 0.
  - A write while `full` is 1 is dropped. The pointers do not change, and there is no error flag.
  - `full` is sampled in the same cycle as the write. A pop in that cycle does not make room for it.
- FIFO pop: show-ahead. The head entry is visible combinationally to the serializer. A pop only advances `rd_ptr`.
- Flags come from pointer compare:
  - `empty` when `wr_ptr == rd_ptr`.
  - `full` when the MSBs differ and the low `PTR_WIDTH` bits are equal.
  - Pointers wrap modulo `2*FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when `empty` is 0, load the head into the shift register, pop, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift register bit 0 for `CLKS_PER_BIT` cycles, then shift right.
    - After bit `DATA_WIDTH-1`, go to STOP.
    - The bit index counter is `$clog2(DATA_WIDTH)` bits.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On the last cycle of STOP:
    - If `empty` is 0: load, pop, and go directly to START. Frames run back to back with no idle gap.
    - Otherwise go to IDLE.
- Baud counter: `$clog2(CLKS_PER_BIT)` bits. It counts 0..`CLKS_PER_BIT-1`, clears on every state change, and wraps at terminal count.
- Frame length is exactly `(DATA_WIDTH+2)*CLKS_PER_BIT` cycles.
- A push and a pop in the same cycle are both performed. Occupancy is unchanged.

## Timing
- Push-to-line latency, with FIFO empty and state IDLE: `wr_en` high in cycle 0 gives `empty`=0 in cycle 1 and `tx`=0 from cycle 2.
- `busy` rises in the same cycle `tx` falls for the start bit. It falls in the first IDLE cycle after the stop bit.
- `full`/`empty` update one cycle after the push or pop edge.
- Reset mid-frame: `rst` sampled high at any edge forces, in the next cycle, `tx`=1, `busy`=0 and `empty`=1. No partial frame resumes.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_tx_state_t` (IDLE, START, DATA, STOP).
  - Frame constants: start level 0, stop level 1, idle level 1.
- Sub-module `uart_tx_fifo`: a synchronous show-ahead FIFO with `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`.
- Top level `uart_tx`: FSM, baud counter, bit counter, shift register and `tx` register.

## Test plan
Run all scenarios with `CLKS_PER_BIT`=4, `FIFO_DEPTH`=16.
- Reset then idle for 20 cycles: `tx`=1, `busy`=0, `empty`=1, `full`=0 throughout.
- Push 0xA5 in cycle 0:
  - `tx`=0 in cycles 2–5.
  - Then bits 1,0,1,0,0,1,0,1, four cycles each, over cycles 6–37.
  - Stop bit high in cycles 38–41.
  - `busy` high in cycles 2–41 and low at 42.
- Push 0x00, 0xFF, 0x3C in consecutive cycles: three frames of 40 cycles each, back to back. `tx` falls at cycle 2, 42 and 82, with no idle gap.
- Push 18 bytes in cycles 0–17:
  - One byte is popped at cycle 1, so `full`=1 after the 17th push.
  - The 18th byte is dropped.
  - Exactly 17 frames come out with correct data, and `empty`=1 after the last pop.
- While `full`=1 and a pop occurs, push 0x77 in the same cycle: the byte is dropped, and 0x77 never appears on `tx`.
- Push 3 bytes, then assert `rst` during data bit 3 of frame 1:
  - Next cycle: `tx`=1, `busy`=0, `empty`=1.
  - No further frames.
  - A new push of 0x5A after reset produces a correct single frame.
